seq_checker: RTL and testbench

Receiving-end checker for the 4-bit incrementing sequence stream produced by the enable-gated counter chain. It samples a `W`-bit word on every enabled cycle and predicts the next value as previous + 1 mod 2^W. It locks after `LOCK_CNT` consecutive in-sequence words and counts mismatches while locked. It drops back to hunting after `UNLOCK_CNT` consecutive misses. It sits downstream of the generator, in the same clock domain, as a self-check monitor.

---
 rtl/seq_checker_if.sv | 12 +
 rtl/seq_checker.sv | 79 +++++++
 tb/tb_seq_checker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_checker_if.sv
// seq_checker_if: sample stream in (en, d, clr_err) and checker status out (locked, err, err_cnt, expected)
interface seq_checker_if #(parameter int W = 4, parameter int ERR_W = 8) ();
  logic en;
  logic [W-1:0] d;
  logic clr_err;
  logic locked;
  logic err;
  logic [ERR_W-1:0] err_cnt;
  logic [W-1:0] expected;
  modport master (output en, d, clr_err, input locked, err, err_cnt, expected);
  modport slave (input en, d, clr_err, output locked, err, err_cnt, expected);
endinterface

// File: rtl/seq_checker.sv
// seq_checker: incrementing-sequence lock/error checker; clk, async active-low rst_b, bus = seq_checker_if.slave
module seq_checker #(
  parameter int W = 4,
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic rst_b,
  seq_checker_if.slave bus
);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(UNLOCK_CNT + 1);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
  state_t state, state_n;
  logic [W-1:0] exp_q, exp_n;
  logic [MC_W-1:0] mc, mc_n;
  logic [MS_W-1:0] ms, ms_n;
  logic err_q, err_n, hit;
  logic [ERR_W-1:0] cnt_q, cnt_n, cnt_base;
  always_comb begin
    hit = bus.d == exp_q;
    state_n = state;
    exp_n = exp_q;
    mc_n = mc;
    ms_n = ms;
    err_n = 1'b0;
    if (bus.en) begin
      case (state)
        HUNT: begin
          exp_n = bus.d + 1'b1;
          mc_n = 1;
          state_n = SYNC;
        end
        SYNC: begin
          exp_n = bus.d + 1'b1;
          mc_n = hit ? mc + 1'b1 : MC_W'(1);
          if (hit && mc_n == MC_W'(LOCK_CNT)) begin
            state_n = LOCKED;
            ms_n = '0;
          end
        end
        LOCKED: begin
          ms_n = hit ? '0 : ms + 1'b1;
          err_n = !hit;
          exp_n = exp_q + 1'b1;
          if (!hit && ms_n == MS_W'(UNLOCK_CNT)) begin
            state_n = HUNT;
            exp_n = exp_q;
          end
        end
        default: state_n = HUNT;
      endcase
    end
    cnt_base = bus.clr_err ? '0 : cnt_q;
    cnt_n = (err_n && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= HUNT;
      exp_q <= '0;
      mc <= '0;
      ms <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      exp_q <= exp_n;
      mc <= mc_n;
      ms <= ms_n;
      err_q <= err_n;
      cnt_q <= cnt_n;
    end
  end
  assign bus.locked = state == LOCKED;
  assign bus.err = err_q;
  assign bus.err_cnt = cnt_q;
  assign bus.expected = exp_q;
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: randomized scoreboard bench for seq_checker against a stream-level reference model
module tb_seq_checker;
  localparam int W = 4, LOCK = 4, UNLOCK = 3, ERR_W = 8, MOD = 16, SAT = 255;
  logic clk = 1'b1;
  logic rst_b = 1'b0;
  seq_checker_if #(.W(W), .ERR_W(ERR_W)) bus ();
  seq_checker #(.W(W), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(ERR_W)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic locked;
    logic err;
    logic [7:0] errs;
    logic [3:0] pred;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  int m_locked, m_run, m_miss, m_errs, m_pred, m_err, gen;
  task automatic model_reset();
    m_locked = 0;
    m_run = 0;
    m_miss = 0;
    m_errs = 0;
    m_pred = 0;
    m_err = 0;
  endtask
  task automatic step(input bit e, input int dv, input bit c);
    @(negedge clk);
    bus.en = e;
    bus.d = dv[3:0];
    bus.clr_err = c;
    m_err = 0;
    if (c) m_errs = 0;
    if (e) begin
      if (!m_locked) begin
        m_run = (m_run > 0 && dv == m_pred) ? m_run + 1 : 1;
        m_pred = (dv + 1) % MOD;
        if (m_run == LOCK) begin
          m_locked = 1;
          m_miss = 0;
        end
      end else if (dv == m_pred) begin
        m_miss = 0;
        m_pred = (m_pred + 1) % MOD;
      end else begin
        m_err = 1;
        m_errs = (m_errs < SAT) ? m_errs + 1 : SAT;
        m_miss++;
        if (m_miss == UNLOCK) begin
          m_locked = 0;
          m_run = 0;
        end else m_pred = (m_pred + 1) % MOD;
      end
    end
    q.push_back({m_locked[0], m_err[0], m_errs[7:0], m_pred[3:0]});
  endtask
  task automatic check_zero(input string name);
    n_checks++;
    if ({bus.locked, bus.err, bus.err_cnt, bus.expected} !== '0) begin
      n_fail++;
      $display("FAIL %s t=%0t: got locked=%0b err=%0b err_cnt=%0d expected=%0d, want all 0",
               name, $time, bus.locked, bus.err, bus.err_cnt, bus.expected);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3 rst_b = 1'b0;
    #1 check_zero("async_reset");
    bus.en = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_checks++;
        if ({bus.locked, bus.err, bus.err_cnt, bus.expected} !== x) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t: got locked=%0b err=%0b err_cnt=%0d expected=%0d, want locked=%0b err=%0b err_cnt=%0d expected=%0d",
                   $time, bus.locked, bus.err, bus.err_cnt, bus.expected, x.locked, x.err, x.errs, x.pred);
        end
      end
    end
  end
  initial begin
    bus.en = 1'b0;
    bus.d = '0;
    bus.clr_err = 1'b0;
    model_reset();
    #12 check_zero("reset_state");
    #13 rst_b = 1'b1;
    for (int i = 1; i <= 4; i++) step(1, i, 0);
    for (int i = 5; i <= 17; i++) step(1, i % MOD, 0);
    for (int i = 2; i <= 5; i++) step(1, i, 0);
    step(1, 9, 0);
    step(1, 7, 0);
    step(0, 3, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 8; i <= 11; i++) step(1, i, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 5, 0);
    step(1, 6, 0);
    for (int i = 10; i <= 13; i++) step(1, i, 0);
    for (int k = 0; k < 140; k++) begin
      step(1, (m_pred + 5) % MOD, 0);
      step(1, (m_pred + 7) % MOD, 0);
      step(1, m_pred, 0);
      if (k % 9 == 0) step(0, 0, 0);
    end
    step(1, (m_pred + 3) % MOD, 0);
    step(1, (m_pred + 3) % MOD, 1);
    step(1, m_pred, 1);
    gen = m_pred;
    for (int i = 0; i < 2500; i++) begin
      bit e, c;
      int v;
      e = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 49) == 0;
      v = ($urandom_range(0, 19) == 0 || (i % 400) < 4) ? (gen + 8) % MOD : gen;
      step(e, v, c);
      if (e) gen = (gen + 1) % MOD;
      if (i == 1200) begin
        do_reset();
        gen = $urandom_range(0, 15);
      end
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
